axil_mem_tester: RTL

AXI4-Lite initiator that exercises the SDRAM path end to end: it writes a pseudo-random word sequence over an address range, reads the same range back, and reports mismatches. It sits on the 50 MHz fabric clock and drives the same AXI-Lite slave port that the PS master normally uses; a top-level mux selects between the two. It provides a self-contained hardware memory test that needs no software.

---
 rtl/axil_mem_tester.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_mem_tester.sv
// axil_mem_tester: AXI4-Lite initiator memory test.
// Writes an LFSR word stream over a range, reads it back, counts errors.
module axil_mem_tester #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 24
) (
  input  logic                    ACLK,
  input  logic                    ARSTN,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [CNT_WIDTH-1:0]    num_words,
  input  logic [31:0]             seed,
  output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]              m_axil_awprot,
  output logic                    m_axil_awvalid,
  input  logic                    m_axil_awready,
  output logic [DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                    m_axil_wvalid,
  input  logic                    m_axil_wready,
  input  logic [1:0]              m_axil_bresp,
  input  logic                    m_axil_bvalid,
  output logic                    m_axil_bready,
  output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]              m_axil_arprot,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,
  input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]              m_axil_rresp,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr
);

  localparam logic [DATA_WIDTH-1:0] POLY =
    DATA_WIDTH'(32'h8020_0003);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] AMASK = ~ADDR_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_FIN
  } state_e;

  state_e                state_q, state_d;
  logic                  issued_q, issued_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CNT_WIDTH-1:0]  err_q, err_d;
  logic [ADDR_WIDTH-1:0] first_q, first_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  err_hit;
  logic                  last;
  logic [ADDR_WIDTH-1:0] base_al;
  logic [DATA_WIDTH-1:0] seed_nz;
  logic [DATA_WIDTH-1:0] lfsr_nx;

  // Helper terms: aligned base, nonzero seed, LFSR step, last word.
  always_comb begin
    base_al = base_addr & AMASK;
    seed_nz = (seed == '0) ? DATA_WIDTH'(1) : seed;
    lfsr_nx = {1'b0, lfsr_q[DATA_WIDTH-1:1]}
            ^ (lfsr_q[0] ? POLY : '0);
    last    = (cnt_q == CNT_WIDTH'(1));
  end

  // Next-state and datapath updates for the test sequence.
  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    base_d    = base_q;
    addr_d    = addr_q;
    num_d     = num_q;
    cnt_d     = cnt_q;
    seed_d    = seed_q;
    lfsr_d    = lfsr_q;
    err_d     = err_q;
    first_d   = first_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_hit   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_al;
          addr_d  = base_al;
          num_d   = num_words;
          cnt_d   = num_words;
          seed_d  = seed_nz;
          lfsr_d  = seed_nz;
          err_d   = '0;
          first_d = '0;
          if (num_words == '0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            busy_d  = 1'b1;
            done_d  = 1'b0;
            state_d = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (!issued_q) begin
          issued_d  = 1'b1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = addr_q;
          wdata_d   = lfsr_q;
        end else begin
          if (m_axil_awready) awvalid_d = 1'b0;
          if (m_axil_wready) wvalid_d = 1'b0;
          if ((!awvalid_q || m_axil_awready) &&
              (!wvalid_q || m_axil_wready)) begin
            issued_d = 1'b0;
            state_d  = S_WR_RESP;
          end
        end
      end
      S_WR_RESP: begin
        if (m_axil_bvalid) begin
          err_hit = (m_axil_bresp != 2'b00);
          addr_d  = addr_q + STRIDE;
          lfsr_d  = lfsr_nx;
          cnt_d   = cnt_q - CNT_WIDTH'(1);
          if (last) begin
            addr_d  = base_q;
            lfsr_d  = seed_q;
            cnt_d   = num_q;
            state_d = S_RD_REQ;
          end else begin
            state_d = S_WR_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (!issued_q) begin
          issued_d  = 1'b1;
          arvalid_d = 1'b1;
          araddr_d  = addr_q;
        end else if (m_axil_arready) begin
          issued_d  = 1'b0;
          arvalid_d = 1'b0;
          state_d   = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (m_axil_rvalid) begin
          err_hit = (m_axil_rresp != 2'b00) ||
                    (m_axil_rdata != lfsr_q);
          addr_d  = addr_q + STRIDE;
          lfsr_d  = lfsr_nx;
          cnt_d   = cnt_q - CNT_WIDTH'(1);
          if (last) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (err_hit) begin
      if (err_q != '1) err_d = err_q + CNT_WIDTH'(1);
      if (err_q == '0) first_d = addr_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      state_q   <= S_IDLE;
      issued_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      num_q     <= '0;
      cnt_q     <= '0;
      seed_q    <= '0;
      lfsr_q    <= '0;
      err_q     <= '0;
      first_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      num_q     <= num_d;
      cnt_q     <= cnt_d;
      seed_q    <= seed_d;
      lfsr_q    <= lfsr_d;
      err_q     <= err_d;
      first_q   <= first_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = '1;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = (state_q == S_WR_RESP);
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = (state_q == S_RD_RESP);
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = done_q && (err_q == '0);
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule
